cyclic_shift_detect: RTL and testbench

- Receive-side counterpart of the PUCCH cyclic-shift generator. Operates on one PRB: 12 de-based samples z[n] = y[n]·conj(r_base[n]).
- Correlates the 12 samples against all 12 candidate cyclic shifts alpha_k = (2pi/12)·k and selects the strongest.
- Reports the detected shift index, the same shift in 1/24-cycle units (the generator's output convention), the peak energy and a DTX flag.
- Sits between the RE demapper/base-sequence conjugate multiplier and the PUCCH format 0 UCI decision logic.

---
 rtl/cyclic_shift_detect.sv | 214 +++++++++++++++++++++
 tb/tb_cyclic_shift_detect.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cyclic_shift_detect.sv
// Cyclic-shift detector for one PRB: correlates 12 de-based samples against all
// 12 PUCCH cyclic shifts, then serially searches for the strongest shift.
module cyclic_shift_detect #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = DATA_W + 5,
  parameter int NSC    = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DATA_W-1:0] i_re,
  input  logic signed [DATA_W-1:0] i_im,
  input  logic [2*ACC_W:0]         i_threshold,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [3:0]               o_cs_idx,
  output logic [4:0]               o_cyc_part_24,
  output logic [2*ACC_W:0]         o_energy,
  output logic                     o_dtx,
  output logic [1:0]               o_dbg_state
);

  localparam int PW = 2*DATA_W + 1;
  localparam int EW = 2*ACC_W + 1;
  localparam logic [3:0] LAST = 4'(NSC - 1);

  typedef enum logic [1:0] {COLLECT = 2'd0, SEARCH = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; o_ready is high only in COLLECT, o_valid only in DONE, so they never overlap.
  state_t                   state_q, state_d;
  logic [3:0]               n_q, n_d;
  logic signed [ACC_W-1:0]  cr_q [NSC];
  logic signed [ACC_W-1:0]  cr_d [NSC];
  logic signed [ACC_W-1:0]  ci_q [NSC];
  logic signed [ACC_W-1:0]  ci_d [NSC];
  logic signed [ACC_W-1:0]  inc_r [NSC];
  logic signed [ACC_W-1:0]  inc_i [NSC];
  logic [EW-1:0]            thr_q, thr_d;
  logic [3:0]               k_q, k_d;
  logic [EW-1:0]            e_q, e_d;
  logic [3:0]               eidx_q, eidx_d;
  logic                     evld_q, evld_d;
  logic [EW-1:0]            max_q, max_d;
  logic [3:0]               best_q, best_d;
  logic                     dtx_q, dtx_d;
  logic [3:0]               k_sel;
  logic signed [EW-1:0]     crx, cix;
  logic [EW-1:0]            e_sel;
  logic signed [PW-1:0]     re_x, im_x;

  function automatic logic signed [15:0] cos_lut(input logic [3:0] m);
    case (m)
      4'd0:    cos_lut =  16'sd32767;
      4'd1:    cos_lut =  16'sd28377;
      4'd2:    cos_lut =  16'sd16384;
      4'd4:    cos_lut = -16'sd16384;
      4'd5:    cos_lut = -16'sd28377;
      4'd6:    cos_lut = -16'sd32767;
      4'd7:    cos_lut = -16'sd28377;
      4'd8:    cos_lut = -16'sd16384;
      4'd10:   cos_lut =  16'sd16384;
      4'd11:   cos_lut =  16'sd28377;
      default: cos_lut =  16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] sin_lut(input logic [3:0] m);
    case (m)
      4'd1:    sin_lut =  16'sd16384;
      4'd2:    sin_lut =  16'sd28377;
      4'd3:    sin_lut =  16'sd32767;
      4'd4:    sin_lut =  16'sd28377;
      4'd5:    sin_lut =  16'sd16384;
      4'd7:    sin_lut = -16'sd16384;
      4'd8:    sin_lut = -16'sd28377;
      4'd9:    sin_lut = -16'sd32767;
      4'd10:   sin_lut = -16'sd28377;
      4'd11:   sin_lut = -16'sd16384;
      default: sin_lut =  16'sd0;
    endcase
  endfunction

  // Per-shift increment z[n]*exp(-j*alpha_k*n), floored back to integer scale.
  always_comb begin
    re_x = PW'(i_re);
    im_x = PW'(i_im);
    for (int k = 0; k < NSC; k++) begin
      logic [3:0]           m;
      logic signed [PW-1:0] cx, sx, pr, pi;
      m  = 4'((k * int'(n_q)) % NSC);
      cx = PW'(cos_lut(m));
      sx = PW'(sin_lut(m));
      pr = re_x * cx + im_x * sx;
      pi = im_x * cx - re_x * sx;
      inc_r[k] = ACC_W'(pr >>> 15);
      inc_i[k] = ACC_W'(pi >>> 15);
    end
  end

  always_comb begin
    k_sel = (k_q <= LAST) ? k_q : 4'd0;
    crx   = EW'(cr_q[k_sel]);
    cix   = EW'(ci_q[k_sel]);
    e_sel = $unsigned(crx * crx) + $unsigned(cix * cix);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    thr_d   = thr_q;
    k_d     = k_q;
    e_d     = e_q;
    eidx_d  = eidx_q;
    evld_d  = 1'b0;
    max_d   = max_q;
    best_d  = best_q;
    dtx_d   = dtx_q;

    // Strict greater-than keeps the lowest k on ties.
    if (evld_q && (e_q > max_q)) begin
      max_d  = e_q;
      best_d = eidx_q;
    end

    case (state_q)
      COLLECT: begin
        if (i_valid) begin
          for (int k = 0; k < NSC; k++) begin
            cr_d[k] = cr_q[k] + inc_r[k];
            ci_d[k] = ci_q[k] + inc_i[k];
          end
          if (n_q == LAST) begin
            state_d = SEARCH;
            n_d     = 4'd0;
            thr_d   = i_threshold;
            k_d     = 4'd0;
            max_d   = '0;
            best_d  = 4'd0;
          end else begin
            n_d = n_q + 4'd1;
          end
        end
      end
      SEARCH: begin
        if (k_q <= LAST) begin
          e_d    = e_sel;
          eidx_d = k_q;
          evld_d = 1'b1;
          k_d    = k_q + 4'd1;
        end
        if (evld_q && (eidx_q == LAST)) begin
          state_d = DONE;
          dtx_d   = (max_d < thr_q);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = COLLECT;
          n_d     = 4'd0;
          for (int k = 0; k < NSC; k++) begin
            cr_d[k] = '0;
            ci_d[k] = '0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      n_q     <= 4'd0;
      for (int k = 0; k < NSC; k++) begin
        cr_q[k] <= '0;
        ci_q[k] <= '0;
      end
      thr_q   <= '0;
      k_q     <= 4'd0;
      e_q     <= '0;
      eidx_q  <= 4'd0;
      evld_q  <= 1'b0;
      max_q   <= '0;
      best_q  <= 4'd0;
      dtx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      thr_q   <= thr_d;
      k_q     <= k_d;
      e_q     <= e_d;
      eidx_q  <= eidx_d;
      evld_q  <= evld_d;
      max_q   <= max_d;
      best_q  <= best_d;
      dtx_q   <= dtx_d;
    end
  end

  assign o_ready       = (state_q == COLLECT);
  assign o_valid       = (state_q == DONE);
  assign o_cs_idx      = best_q;
  assign o_cyc_part_24 = {best_q, 1'b0};
  assign o_energy      = max_q;
  assign o_dtx         = dtx_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_cyclic_shift_detect.sv
// Directed bench for cyclic_shift_detect: hand-computed expected results go into a
// queue when a block is issued; a negedge monitor pops and checks on each result handshake.
module tb_cyclic_shift_detect;

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + 5;
  localparam int EW     = 2*ACC_W + 1;
  localparam int XW     = 4 + 5 + EW + 1;
  localparam logic [EW-1:0] E_PEAK = 43'd36859392144;
  localparam logic [EW-1:0] E_K11  = 43'd36859392160;

  logic                     i_clk = 1'b0;
  logic                     i_rst_n = 1'b0;
  logic                     i_valid = 1'b0;
  logic                     o_ready;
  logic signed [DATA_W-1:0] i_re = '0;
  logic signed [DATA_W-1:0] i_im = '0;
  logic [EW-1:0]            i_threshold = '0;
  logic                     o_valid;
  logic                     i_ready = 1'b1;
  logic [3:0]               o_cs_idx;
  logic [4:0]               o_cyc_part_24;
  logic [EW-1:0]            o_energy;
  logic                     o_dtx;
  logic [1:0]               o_dbg_state;

  cyclic_shift_detect #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NSC(12)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_re          (i_re),
    .i_im          (i_im),
    .i_threshold   (i_threshold),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_cs_idx      (o_cs_idx),
    .o_cyc_part_24 (o_cyc_part_24),
    .o_energy      (o_energy),
    .o_dtx         (o_dtx),
    .o_dbg_state   (o_dbg_state)
  );

  // Clock and cycle count
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [XW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int last_acc = 0;
  bit busy = 1'b0;
  bit ready_err = 1'b0;
  bit stall_err = 1'b0;
  bit valid_prev = 1'b0;
  logic [XW-1:0] snap;
  logic signed [DATA_W-1:0] vre [12];
  logic signed [DATA_W-1:0] vim [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor
  always @(negedge i_clk) begin
    logic [XW-1:0] e;
    if (!i_rst_n) begin
      valid_prev = 1'b0;
    end else begin
      if (busy && o_ready) ready_err = 1'b1;
      if (o_valid) begin
        if (!valid_prev) begin
          check("latency", 64'(cyc - last_acc), 64'd13);
          snap = {o_cs_idx, o_cyc_part_24, o_energy, o_dtx};
          stall_err = 1'b0;
        end else if ({o_cs_idx, o_cyc_part_24, o_energy, o_dtx} !== snap) begin
          stall_err = 1'b1;
        end
        if (i_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got idx %0d, expected no result", o_cs_idx);
          end else begin
            e = exp_q.pop_front();
            check("cs_idx", 64'(o_cs_idx), 64'(e[XW-1 -: 4]));
            check("cyc_part_24", 64'(o_cyc_part_24), 64'(e[XW-5 -: 5]));
            check("energy", 64'(o_energy), 64'(e[EW:1]));
            check("dtx", 64'(o_dtx), 64'(e[0]));
          end
          check("stable_while_stalled", 64'(stall_err), 64'd0);
          check("ready_low_while_busy", 64'(ready_err), 64'd0);
          busy = 1'b0;
          ready_err = 1'b0;
        end
      end
      valid_prev = o_valid;
    end
  end

  // Drivers
  task automatic send(input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im);
    int guard = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_re = re;
    i_im = im;
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got o_ready 0, expected 1 within 100 cycles");
    end
    @(posedge i_clk);
    #1;
    last_acc = cyc;
    i_valid = 1'b0;
  endtask

  task automatic run_block(input logic [EW-1:0] thr, input logic [3:0] idx, input logic [4:0] cp,
                           input logic [EW-1:0] en, input logic dtx, input int gap_max, input bit stall);
    int guard;
    exp_q.push_back({idx, cp, en, dtx});
    i_threshold = thr;
    i_ready = !stall;
    ready_err = 1'b0;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge i_clk);
      send(vre[n], vim[n]);
    end
    busy = 1'b1;
    if (stall) begin
      guard = 0;
      while (!o_valid && guard < 40) begin
        @(negedge i_clk);
        guard++;
      end
      repeat (20) @(posedge i_clk);
      #1 i_ready = 1'b1;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge i_clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_cs_idx"}, 64'(o_cs_idx), 64'd0);
    check({tag, "_cyc_part"}, 64'(o_cyc_part_24), 64'd0);
    check({tag, "_energy"}, 64'(o_energy), 64'd0);
    check({tag, "_dtx"}, 64'(o_dtx), 64'd0);
  endtask

  task automatic load_const(input logic signed [DATA_W-1:0] a);
    for (int n = 0; n < 12; n++) begin vre[n] = a; vim[n] = '0; end
  endtask

  task automatic load_alt();
    for (int n = 0; n < 12; n++) begin vre[n] = (n % 2 == 0) ? 16'sd16000 : -16'sd16000; vim[n] = '0; end
  endtask

  task automatic load_k3();
    for (int n = 0; n < 12; n++) begin
      case (n % 4)
        0:       begin vre[n] =  16'sd16000; vim[n] =  16'sd0;     end
        1:       begin vre[n] =  16'sd0;     vim[n] =  16'sd16000; end
        2:       begin vre[n] = -16'sd16000; vim[n] =  16'sd0;     end
        default: begin vre[n] =  16'sd0;     vim[n] = -16'sd16000; end
      endcase
    end
  endtask

  task automatic load_k11();
    logic signed [DATA_W-1:0] tr [12];
    logic signed [DATA_W-1:0] ti [12];
    tr = '{16000, 13856, 8000, 0, -8000, -13856, -16000, -13856, -8000, 0, 8000, 13856};
    ti = '{0, -8000, -13856, -16000, -13856, -8000, 0, 8000, 13856, 16000, 13856, 8000};
    for (int n = 0; n < 12; n++) begin vre[n] = tr[n]; vim[n] = ti[n]; end
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    reset_checks("reset");

    load_const(16'sd16000);
    run_block(43'd1000, 4'd0, 5'd0, E_PEAK, 1'b0, 0, 1'b0);
    load_alt();
    run_block(43'd1000, 4'd6, 5'd12, E_PEAK, 1'b0, 0, 1'b0);
    load_k3();
    run_block(43'd1000, 4'd3, 5'd6, E_PEAK, 1'b0, 0, 1'b0);
    load_k11();
    run_block(43'd1000, 4'd11, 5'd22, E_K11, 1'b0, 0, 1'b0);
    load_const(16'sd0);
    run_block(43'd1, 4'd0, 5'd0, 43'd0, 1'b1, 0, 1'b0);

    // DTX threshold boundary: equal is not DTX, one above is
    load_const(16'sd16000);
    run_block(E_PEAK, 4'd0, 5'd0, E_PEAK, 1'b0, 0, 1'b0);
    run_block(E_PEAK + 43'd1, 4'd0, 5'd0, E_PEAK, 1'b1, 0, 1'b0);

    load_k3();
    run_block(43'd1000, 4'd3, 5'd6, E_PEAK, 1'b0, 3, 1'b1);

    // Aborted block: 7 samples of garbage, reset, then a clean k=0 block
    load_k11();
    for (int n = 0; n < 7; n++) send(vre[n], vim[n]);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_valid", 64'(o_valid), 64'd0);
    load_const(16'sd16000);
    run_block(43'd1000, 4'd0, 5'd0, E_PEAK, 1'b0, 0, 1'b0);

    repeat (5) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
